// File: rtl/gpio_mmio_bank.sv
// gpio_mmio_bank
//   Memory-mapped GPIO bank with an eight-word register window on the shared
//   address/data bus. It drives N_IO bidirectional pins with per-pin direction,
//   synchronises pin inputs, supports atomic output set/clear, and captures
//   rising/falling edges into sticky write-1-to-clear flags that raise irq.
//
//   Register offsets from BASE_ADDR:
//     0 DIR, 1 OUT, 2 OUT_SET, 3 OUT_CLR, 4 IN, 5 RISE_EN, 6 FALL_EN, 7 EVENT
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   mem_address  bus word address
//   mem_data     shared tri-state data bus (driven only on a selected read)
//   mem_read     read strobe, combinational read data
//   mem_write_en write strobe, sampled on the rising edge
//   sel          address falls inside the register window
//   io           GPIO pins
//   irq          OR of all EVENT flags
module gpio_mmio_bank #(
  parameter int unsigned N_IO        = 13,
  parameter logic [31:0] BASE_ADDR   = 32'd248,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      mem_address,
  inout  logic [63:0]      mem_data,
  input  logic             mem_read,
  input  logic             mem_write_en,
  output logic             sel,
  inout  logic [N_IO-1:0]  io,
  output logic             irq
);

  typedef enum logic [2:0] {
    R_DIR     = 3'd0,
    R_OUT     = 3'd1,
    R_OUT_SET = 3'd2,
    R_OUT_CLR = 3'd3,
    R_IN      = 3'd4,
    R_RISE_EN = 3'd5,
    R_FALL_EN = 3'd6,
    R_EVENT   = 3'd7
  } reg_t;

  logic [N_IO-1:0] dir_q, out_q, rise_en_q, fall_en_q, event_q, prev_q;
  logic [N_IO-1:0] sync_q [SYNC_STAGES];
  logic [N_IO-1:0] in_lvl, rise, fall, event_clr, event_next, wdata;
  logic [63:0]     rdata;
  logic [32:0]     top_addr;
  logic            wr;
  reg_t            idx;
  logic            unused_bus_bits;

  // Window end computed one bit wider so a window touching the top of the
  // address space does not wrap.
  assign top_addr = {1'b0, BASE_ADDR} + 33'd7;
  assign sel      = (mem_address >= BASE_ADDR) && ({1'b0, mem_address} <= top_addr);

  // Only the low three bits of the offset matter inside the window.
  assign idx   = reg_t'(mem_address[2:0] - BASE_ADDR[2:0]);
  assign wr    = sel && mem_write_en && !mem_read;
  assign wdata = mem_data[N_IO-1:0];

  // Upper bus bits beyond N_IO carry no state.
  assign unused_bus_bits = ^mem_data;

  assign in_lvl = sync_q[SYNC_STAGES-1];
  assign rise   = in_lvl & ~prev_q & rise_en_q;
  assign fall   = ~in_lvl & prev_q & fall_en_q;
  assign irq    = |event_q;

  // Capture is OR-ed after the clear so a same-edge capture wins over W1C.
  always_comb begin
    event_clr  = '0;
    if (wr && idx == R_EVENT) event_clr = wdata;
    event_next = (event_q & ~event_clr) | rise | fall;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      event_q   <= '0;
      prev_q    <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= io;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q  <= in_lvl;
      event_q <= event_next;
      if (wr) begin
        case (idx)
          R_DIR:     dir_q     <= wdata;
          R_OUT:     out_q     <= wdata;
          R_OUT_SET: out_q     <= out_q | wdata;
          R_OUT_CLR: out_q     <= out_q & ~wdata;
          R_RISE_EN: rise_en_q <= wdata;
          R_FALL_EN: fall_en_q <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      R_DIR:     rdata[N_IO-1:0] = dir_q;
      R_OUT:     rdata[N_IO-1:0] = out_q;
      R_IN:      rdata[N_IO-1:0] = in_lvl;
      R_RISE_EN: rdata[N_IO-1:0] = rise_en_q;
      R_FALL_EN: rdata[N_IO-1:0] = fall_en_q;
      R_EVENT:   rdata[N_IO-1:0] = event_q;
      default:   rdata = '0;
    endcase
  end

  assign mem_data = (sel && mem_read) ? rdata : 'z;

  for (genvar g = 0; g < N_IO; g++) begin : g_pin
    assign io[g] = dir_q[g] ? out_q[g] : 1'bz;
  end

endmodule

// File: tb/tb_gpio_mmio_bank.sv
// Testbench for gpio_mmio_bank: default instance (13 pins at 248) plus a
// 64-pin instance at 1000 for the full-width reset/write collision case.
module tb_gpio_mmio_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   checks = 0;
  int   errors = 0;

  // ---------------- instance A: defaults ----------------
  logic [31:0] addr_a;
  logic        rd_a, we_a, drv_a;
  logic [63:0] val_a;
  logic        sel_a, irq_a;
  wire  [63:0] bus_a;
  wire  [12:0] io_a;
  logic [12:0] pin_en_a, pin_val_a;

  assign bus_a = drv_a ? val_a : 'z;
  for (genvar g = 0; g < 13; g++) begin : g_pa
    assign io_a[g] = pin_en_a[g] ? pin_val_a[g] : 1'bz;
  end

  gpio_mmio_bank dut_a (
    .clock(clk), .reset(reset), .mem_address(addr_a), .mem_data(bus_a),
    .mem_read(rd_a), .mem_write_en(we_a), .sel(sel_a), .io(io_a), .irq(irq_a)
  );

  // ---------------- instance B: 64 pins at 1000 ----------------
  logic [31:0] addr_b;
  logic        rd_b, we_b, drv_b;
  logic [63:0] val_b;
  logic        sel_b, irq_b;
  wire  [63:0] bus_b;
  wire  [63:0] io_b;
  logic [63:0] pin_en_b, pin_val_b;

  assign bus_b = drv_b ? val_b : 'z;
  for (genvar g = 0; g < 64; g++) begin : g_pb
    assign io_b[g] = pin_en_b[g] ? pin_val_b[g] : 1'bz;
  end

  gpio_mmio_bank #(.N_IO(64), .BASE_ADDR(32'd1000), .SYNC_STAGES(2)) dut_b (
    .clock(clk), .reset(reset), .mem_address(addr_b), .mem_data(bus_b),
    .mem_read(rd_b), .mem_write_en(we_b), .sel(sel_b), .io(io_b), .irq(irq_b)
  );

  typedef enum logic [1:0] {V_WR, V_RD, V_IO, V_SEL} vkind_t;
  typedef struct {
    vkind_t      kind;
    logic [31:0] addr;
    logic [63:0] data;   // write data, or expected value
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Combinational read inside the current low phase; consumes no edge.
  task automatic peek_a(input logic [31:0] a, output logic [63:0] d);
    addr_a = a; rd_a = 1'b1;
    #1 d = bus_a;
    rd_a = 1'b0;
    #1;
  endtask

  task automatic write_a(input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    addr_a = a; val_a = d; drv_a = 1'b1; we_a = 1'b1;
    @(posedge clk);
    #1 we_a = 1'b0; drv_a = 1'b0;
  endtask

  task automatic peek_b(input logic [31:0] a, output logic [63:0] d);
    addr_b = a; rd_b = 1'b1;
    #1 d = bus_b;
    rd_b = 1'b0;
    #1;
  endtask

  task automatic write_b(input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    addr_b = a; val_b = d; drv_b = 1'b1; we_b = 1'b1;
    @(posedge clk);
    #1 we_b = 1'b0; drv_b = 1'b0;
  endtask

  logic [63:0] d;

  initial begin
    reset = 1'b1;
    addr_a = '0; rd_a = 1'b0; we_a = 1'b0; drv_a = 1'b0; val_a = '0;
    addr_b = '0; rd_b = 1'b0; we_b = 1'b0; drv_b = 1'b0; val_b = '0;
    pin_en_a = '1; pin_val_a = '0;
    pin_en_b = '1; pin_val_b = '0;

    // reset readback, decode boundaries, then output path
    for (int unsigned i = 0; i < 8; i++) vecs.push_back('{V_RD, 32'd248 + i, 64'd0});
    vecs.push_back('{V_SEL, 32'd247, 64'd0});
    vecs.push_back('{V_SEL, 32'd256, 64'd0});
    vecs.push_back('{V_SEL, 32'd248, 64'd1});
    vecs.push_back('{V_SEL, 32'd255, 64'd1});
    vecs.push_back('{V_WR,  32'd248, 64'h1FFF});
    vecs.push_back('{V_WR,  32'd249, 64'h0A5A});
    vecs.push_back('{V_IO,  32'd0,   64'h0A5A});
    vecs.push_back('{V_WR,  32'd250, 64'h0005});
    vecs.push_back('{V_IO,  32'd0,   64'h0A5F});
    vecs.push_back('{V_WR,  32'd251, 64'h0050});
    vecs.push_back('{V_IO,  32'd0,   64'h0A0F});
    vecs.push_back('{V_RD,  32'd249, 64'h0A0F});
    vecs.push_back('{V_RD,  32'd250, 64'h0});
    vecs.push_back('{V_RD,  32'd251, 64'h0});
    vecs.push_back('{V_RD,  32'd248, 64'h1FFF});
    vecs.push_back('{V_WR,  32'd250, 64'h0});             // set with zero
    vecs.push_back('{V_WR,  32'd251, 64'h0});             // clear with zero
    vecs.push_back('{V_RD,  32'd249, 64'h0A0F});
    vecs.push_back('{V_WR,  32'd249, 64'hFFFF_0000_0000_0A0F}); // upper bits dropped
    vecs.push_back('{V_RD,  32'd249, 64'h0A0F});
    vecs.push_back('{V_RD,  32'd252, 64'h0A0F});          // own drive read back
    vecs.push_back('{V_IO,  32'd0,   64'h0A0F});

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("irq_after_reset", {63'd0, irq_a}, 64'd0);

    foreach (vecs[i]) begin
      // hand pins to the DUT before it starts driving them
      if (vecs[i].kind == V_WR && vecs[i].addr == 32'd248) pin_en_a = '0;
      case (vecs[i].kind)
        V_WR: write_a(vecs[i].addr, vecs[i].data);
        V_RD: begin
          @(negedge clk);
          peek_a(vecs[i].addr, d);
          check($sformatf("vec%0d_rd_%0d", i, vecs[i].addr), d, vecs[i].data);
        end
        V_IO: check($sformatf("vec%0d_io", i), 64'(io_a), vecs[i].data);
        V_SEL: begin
          addr_a = vecs[i].addr;
          #1 check($sformatf("vec%0d_sel_%0d", i, vecs[i].addr), {63'd0, sel_a}, vecs[i].data);
        end
        default: ;
      endcase
    end

    // ---- input synchroniser and rising-edge capture ----
    write_a(248, 64'h0);
    pin_val_a = '0; pin_en_a = '1;
    write_a(253, 64'h0008);
    repeat (4) @(negedge clk);
    peek_a(255, d); check("event_idle", d, 64'h0);
    @(negedge clk);                                   // between edge k-1 and k
    pin_val_a[3] = 1'b1;
    peek_a(252, d); check("in_before_k", d, 64'h0);
    @(negedge clk);                                   // after k
    peek_a(252, d); check("in_after_k", d, 64'h0);
    @(negedge clk);                                   // after k+1
    peek_a(252, d); check("in_after_k1", d, 64'h0008);
    peek_a(255, d); check("event_after_k1", d, 64'h0);
    check("irq_after_k1", {63'd0, irq_a}, 64'd0);
    @(negedge clk);                                   // after k+2
    peek_a(255, d); check("event_after_k2", d, 64'h0008);
    check("irq_after_k2", {63'd0, irq_a}, 64'd1);

    // falling edge with FALL_EN=0: no change; disabling RISE_EN keeps the flag
    pin_val_a[3] = 1'b0;
    repeat (4) @(negedge clk);
    peek_a(255, d); check("fall_disabled", d, 64'h0008);
    write_a(253, 64'h0);
    @(negedge clk);
    peek_a(255, d); check("event_kept_after_disable", d, 64'h0008);
    write_a(255, 64'h0);
    @(negedge clk);
    peek_a(255, d); check("w1c_zero_keeps", d, 64'h0008);
    write_a(255, 64'h0008);
    @(negedge clk);
    peek_a(255, d); check("w1c_clears", d, 64'h0);
    check("irq_cleared", {63'd0, irq_a}, 64'd0);

    // falling-edge capture only
    write_a(254, 64'h0008);
    pin_val_a[3] = 1'b1;
    repeat (4) @(negedge clk);
    peek_a(255, d); check("rise_not_enabled", d, 64'h0);
    pin_val_a[3] = 1'b0;
    repeat (4) @(negedge clk);
    peek_a(255, d); check("fall_captured", d, 64'h0008);
    write_a(255, 64'h0008);
    write_a(254, 64'h0);

    // ---- capture and W1C on the same edge ----
    write_a(253, 64'h0009);
    pin_val_a[0] = 1'b1;
    repeat (4) @(negedge clk);
    peek_a(255, d); check("pin0_event", d, 64'h0001);
    @(negedge clk);                                   // before edge k
    pin_val_a[3] = 1'b1;
    @(negedge clk);                                   // after k
    write_a(255, 64'h0009);                           // sampled at k+2
    @(negedge clk);
    peek_a(255, d); check("collision_set_wins", d, 64'h0008);
    check("collision_irq", {63'd0, irq_a}, 64'd1);

    // ---- reset clears state, including synchroniser ----
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    peek_a(255, d); check("rst_event", d, 64'h0);
    check("rst_irq", {63'd0, irq_a}, 64'd0);
    peek_a(253, d); check("rst_rise_en", d, 64'h0);
    peek_a(252, d); check("rst_in", d, 64'h0);

    // ---- 64-pin instance: reset vs write, full-width pins, read+write ----
    @(negedge clk);
    reset = 1'b1;
    addr_b = 32'd1001; val_b = '1; drv_b = 1'b1; we_b = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; we_b = 1'b0; drv_b = 1'b0;
    peek_b(1001, d); check("b_out_after_reset_write", d, 64'h0);
    pin_en_b = '0;
    write_b(1000, '1);
    write_b(1001, 64'hFFFF_FFFF_FFFF_FFFF);
    check("b_io_all_high", io_b, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) @(negedge clk);
    addr_b = 32'd1004; rd_b = 1'b1; we_b = 1'b1;
    #1 check("b_rd_wr_in", bus_b, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1 rd_b = 1'b0; we_b = 1'b0;
    @(negedge clk);
    peek_b(1001, d); check("b_out_kept", d, 64'hFFFF_FFFF_FFFF_FFFF);
    peek_b(1000, d); check("b_dir_kept", d, 64'hFFFF_FFFF_FFFF_FFFF);
    addr_b = 32'd1008;
    #1 check("b_sel_outside", {63'd0, sel_b}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/gpio_mmio_bank.md
# gpio_mmio_bank

Parametrised memory-mapped GPIO bank that replaces the fixed two-address, 13-pin peripheral logic at the top of the computer. It decodes an eight-word register window on the shared address/data bus and drives `N_IO` bidirectional pins with per-pin direction. Relative to the previous block it adds:
- input synchronisation;
- atomic set/clear of output bits;
- per-pin rising/falling edge capture with write-1-to-clear status;
- an interrupt request output.

## Interface
Parameters:
- `N_IO`, 13, number of pins (1..64).
- `BASE_ADDR`, 32'd248, word address of register 0; window is `BASE_ADDR`..`BASE_ADDR+7`.
- `SYNC_STAGES`, 2, input synchroniser depth (≥2).

Ports:
- `clock`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clock`.
- `mem_address`  in  32  bus word address.
- `mem_data`  inout  64  shared tri-state data bus.
- `mem_read`  in  1  bus read strobe (combinational read).
- `mem_write_en`  in  1  bus write strobe (write on rising edge).
- `sel`  out  1  high when `mem_address` is inside the window; top level uses it to deselect RAM/ROM.
- `io`  inout  `N_IO`  GPIO pins.
- `irq`  out  1  interrupt request, OR of `EVENT`.

## Operation
Register map (offset from `BASE_ADDR`). Bits `[63:N_IO]` are ignored on write and read 0.

| Offset | Name | Access | Behaviour |
|---|---|---|---|
| 0 | `DIR` | RW | 1 = pin driven from `OUT`, 0 = hi-Z. |
| 1 | `OUT` | RW | Output value. |
| 2 | `OUT_SET` | W | `OUT <= OUT \| wdata`; reads 0. |
| 3 | `OUT_CLR` | W | `OUT <= OUT & ~wdata`; reads 0. |
| 4 | `IN` | R | Synchronised pin levels, including pins configured as output (read-back of own drive); writes ignored. |
| 5 | `RISE_EN` | RW | Enable rising-edge capture per pin. |
| 6 | `FALL_EN` | RW | Enable falling-edge capture per pin. |
| 7 | `EVENT` | R / W1C | Sticky edge flags. Bit i sets when an enabled edge is detected on pin i. Writing 1 clears, writing 0 leaves unchanged. |

Decode and bus:
- `sel = (mem_address >= BASE_ADDR) && (mem_address <= BASE_ADDR+7)`. Register index is `mem_address - BASE_ADDR`, 3 bits.
- `mem_data` is driven only when `sel && mem_read`; otherwise hi-Z. Reads are combinational from current register state.
- Write occurs at rising edge when `sel && mem_write_en && !mem_read`. If `mem_read` and `mem_write_en` are both asserted, the write is suppressed.

Input path and edge detection:
- Synchroniser chain `s[0..SYNC_STAGES-1]` samples `io` every cycle. `IN = s[SYNC_STAGES-1]`.
- `prev` register holds the previous `IN`.
- `rise = IN & ~prev & RISE_EN`; `fall = ~IN & prev & FALL_EN`.

Pins: `io[i] = DIR[i] ? OUT[i] : 1'bz`.

Reset (synchronous):
- All registers, synchroniser stages and `prev` clear to 0.
- All pins become hi-Z.
- `irq` = 0 and `mem_data` = hi-Z (unless a read is selected).
- Reset mid-transaction discards the write in that cycle. Reset has priority over all writes and captures.

## Timing
- Write latency: register updates on the rising edge where the write strobe is sampled. For `DIR`/`OUT`, the pin reflects the new value in the following cycle.
- Input latency: a pin level stable before edge k is visible in `IN` after edge k+SYNC_STAGES-1. The `EVENT` bit sets at edge k+SYNC_STAGES, and `irq` rises in that same cycle (combinational OR).
- Simultaneous event capture and W1C on the same bit in the same edge: set wins and the bit stays 1. Other bits clear normally.
- Changing `RISE_EN`/`FALL_EN` affects only edges detected after the write edge. Already-set `EVENT` bits are not cleared by disabling.
- A pulse shorter than one clock period may be missed. This is not an error.
- `OUT_SET`/`OUT_CLR` with zero data leave `OUT` unchanged.

## Test plan
1. **Reset and readback.** Assert `reset` 1 cycle, then read offsets 0..7 → all read 0; `io` all Z; `irq`=0; `sel`=0 at address 247 and 256, `sel`=1 at 248 and 255.
2. **Direction and output.** Write `DIR`=0x1FFF, `OUT`=0x0A5A; then `OUT_SET` 0x0005; then `OUT_CLR` 0x0050 → `io` shows 0x0A5A, then 0x0A5F, then 0x0A0F. `OUT` reads 0x0A0F; `OUT_SET` reads 0.
3. **Input synchroniser.** With `DIR`=0, drive `io[3]` high between edges k-1 and k → `IN` bit 3 reads 1 only after edge k+1 (`SYNC_STAGES`=2), not earlier.
4. **Edge capture and interrupt.** Set `RISE_EN`=0x0008, toggle `io[3]` 0→1 → `EVENT`=0x0008 and `irq`=1 at edge k+2. Toggle 1→0 with `FALL_EN`=0 → no change. Write `EVENT`=0x0008 → 0, `irq`=0.
5. **Set/clear collision.** Schedule a rising edge on pin 3 to be detected on the same edge as a W1C write of 0x0008 → `EVENT` bit 3 remains 1.
6. **Reset and write collision.** With `N_IO`=64 and `BASE_ADDR`=1000: assert `reset` together with a write of 0xFFFF… to `OUT` → `OUT`=0. Then write 64'hFFFF_FFFF_FFFF_FFFF with `DIR` all 1 → all 64 pins high. Read at 1004 with `mem_write_en` also high → no write occurs, `IN` returns 64'hFFFF_FFFF_FFFF_FFFF.
